// File: rtl/nios_system_sound_pkg.sv
// Shared definitions for the sound capture controller: register map, field
// positions and the sample word type.
package nios_system_sound_pkg;

    localparam int SAMPLE_W = 16;
    typedef logic [SAMPLE_W-1:0] sample_t;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_CONTROL = 2'd2;
    localparam logic [1:0] ADDR_DIVIDER = 2'd3;

    localparam int STAT_LEVEL_LSB = 0;
    localparam int STAT_EMPTY_BIT = 8;
    localparam int STAT_FULL_BIT  = 9;
    localparam int STAT_OVF_BIT   = 10;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int CTRL_FLUSH_BIT  = 2;
    localparam int CTRL_THR_LSB    = 8;
    localparam int CTRL_THR_MSB    = 12;
    localparam int THR_W           = CTRL_THR_MSB - CTRL_THR_LSB + 1;

    // A threshold of zero would make the level interrupt fire on an empty FIFO.
    function automatic logic [THR_W-1:0] thresh_min1(input logic [THR_W-1:0] thr);
        thresh_min1 = (thr == 5'd0) ? 5'd1 : thr;
    endfunction

endpackage

// File: rtl/nios_system_sound_fifo.sv
// Synchronous sample FIFO; push and pop may coincide even when full, and
// flush overrides both.
module nios_system_sound_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              flush,
    output logic [DATA_W-1:0] head,
    output logic [LVL_W-1:0]  level,
    output logic              empty,
    output logic              full
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  count_q, count_d;
    logic              push_ok;
    logic              pop_ok;

    assign empty = (count_q == {LVL_W{1'b0}});
    assign full  = (count_q == LVL_W'(DEPTH));
    assign level = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push_ok  = push & (~full | pop);
        pop_ok   = pop & ~empty;
        if (flush) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {LVL_W{1'b0}};
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {LVL_W{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/nios_system_sound_capture_ctrl.sv
// Sound capture controller: sample-rate timer, Avalon-MM register file and
// interrupt generation around the sample FIFO.
module nios_system_sound_capture_ctrl #(
    parameter int DATA_W       = 16,
    parameter int FIFO_DEPTH   = 16,
    parameter int DIV_W        = 16,
    parameter int DIV_RESET    = 1133,
    parameter int THRESH_RESET = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [DATA_W-1:0] in_port,
    output logic              irq
);
    import nios_system_sound_pkg::*;

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]       readdata_q, readdata_d;
    logic              irq_q, irq_d;
    logic              enable_q, enable_d;
    logic              irq_en_q, irq_en_d;
    logic [THR_W-1:0]  threshold_q, threshold_d;
    logic [DIV_W-1:0]  divider_q, divider_d;
    logic [DIV_W-1:0]  counter_q, counter_d;
    logic              overflow_q, overflow_d;

    logic              bus_rd;
    logic              bus_wr;
    logic              tick;
    logic              pop;
    logic              flush;
    logic [31:0]       rd_word;
    logic [THR_W-1:0]  thr_eff;
    logic [DATA_W-1:0] head;
    logic [LVL_W-1:0]  level;
    logic              empty;
    logic              full;
    logic              unused_wdata;

    assign bus_rd       = chipselect & read;
    assign bus_wr       = chipselect & write;
    assign tick         = enable_q & (counter_q == {DIV_W{1'b0}});
    assign pop          = bus_rd & (address == ADDR_DATA) & ~empty;
    assign flush        = bus_wr & (address == ADDR_CONTROL) & writedata[CTRL_FLUSH_BIT];
    assign thr_eff      = thresh_min1(threshold_q);
    assign unused_wdata = ^writedata;
    assign readdata     = readdata_q;
    assign irq          = irq_q;

    nios_system_sound_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tick),
        .push_data (in_port),
        .pop       (pop),
        .flush     (flush),
        .head      (head),
        .level     (level),
        .empty     (empty),
        .full      (full)
    );

    // Read mux; an empty DATA read returns zero without popping.
    always_comb begin
        rd_word = 32'h0000_0000;
        case (address)
            ADDR_DATA: begin
                if (!empty) begin
                    rd_word[DATA_W-1:0] = head;
                end else begin
                    rd_word = 32'h0000_0000;
                end
            end
            ADDR_STATUS: begin
                rd_word[STAT_LEVEL_LSB +: LVL_W] = level;
                rd_word[STAT_EMPTY_BIT]          = empty;
                rd_word[STAT_FULL_BIT]           = full;
                rd_word[STAT_OVF_BIT]            = overflow_q;
            end
            ADDR_CONTROL: begin
                rd_word[CTRL_EN_BIT]                 = enable_q;
                rd_word[CTRL_IRQ_EN_BIT]             = irq_en_q;
                rd_word[CTRL_THR_MSB:CTRL_THR_LSB]   = threshold_q;
            end
            ADDR_DIVIDER: begin
                rd_word[DIV_W-1:0] = divider_q;
            end
            default: begin
                rd_word = 32'h0000_0000;
            end
        endcase
    end

    // Register file, sample timer, overflow and interrupt next-state.
    always_comb begin
        readdata_d  = readdata_q;
        enable_d    = enable_q;
        irq_en_d    = irq_en_q;
        threshold_d = threshold_q;
        divider_d   = divider_q;
        counter_d   = counter_q;
        overflow_d  = overflow_q;

        if (bus_rd) begin
            readdata_d = rd_word;
        end else begin
            readdata_d = readdata_q;
        end

        // Counter sits at the full divider while idle so enabling starts a whole period.
        if (!enable_q || tick) begin
            counter_d = divider_q;
        end else begin
            counter_d = counter_q - DIV_W'(1);
        end

        if (bus_wr) begin
            case (address)
                ADDR_STATUS: begin
                    if (writedata[STAT_OVF_BIT]) begin
                        overflow_d = 1'b0;
                    end else begin
                        overflow_d = overflow_q;
                    end
                end
                ADDR_CONTROL: begin
                    enable_d    = writedata[CTRL_EN_BIT];
                    irq_en_d    = writedata[CTRL_IRQ_EN_BIT];
                    threshold_d = writedata[CTRL_THR_MSB:CTRL_THR_LSB];
                end
                ADDR_DIVIDER: begin
                    divider_d = writedata[DIV_W-1:0];
                    counter_d = writedata[DIV_W-1:0];
                end
                default: begin
                    divider_d = divider_q;
                end
            endcase
        end else begin
            divider_d = divider_q;
        end

        // A dropped sample outweighs a same-cycle clear so the event is never lost.
        if (tick && full && !pop && !flush) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_d;
        end

        irq_d = irq_en_q & ((32'(level) >= 32'(thr_eff)) | overflow_q);
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata_q  <= 32'h0000_0000;
            irq_q       <= 1'b0;
            enable_q    <= 1'b0;
            irq_en_q    <= 1'b0;
            threshold_q <= THR_W'(THRESH_RESET);
            divider_q   <= DIV_W'(DIV_RESET);
            counter_q   <= DIV_W'(DIV_RESET);
            overflow_q  <= 1'b0;
        end else begin
            readdata_q  <= readdata_d;
            irq_q       <= irq_d;
            enable_q    <= enable_d;
            irq_en_q    <= irq_en_d;
            threshold_q <= threshold_d;
            divider_q   <= divider_d;
            counter_q   <= counter_d;
            overflow_q  <= overflow_d;
        end
    end

endmodule
